// File: rtl/key_debounce.sv
// Debounced push-button block with sticky press/release flags and a W1C register port.
// Define KEY_DEBOUNCE_IRQ_EN to add the interrupt mask register and a registered irq.
module key_debounce #(
   parameter int NKEY      = 3,
   parameter int DB_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NKEY-1:0] key_n,
   input  logic            en,
   input  logic            wr,
   input  logic [31:0]     din,
   output logic [31:0]     dout,
   output logic [NKEY-1:0] key_lvl,
   output logic            irq
);

   localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic [NKEY-1:0] meta_reg;
   logic [NKEY-1:0] syn_reg;
   logic [NKEY-1:0] lvl;
   logic [NKEY-1:0] rise;
   logic [NKEY-1:0] fall;
   logic [NKEY-1:0] press_reg;
   logic [NKEY-1:0] rel_reg;
   logic [NKEY-1:0] press_clr;
   logic [NKEY-1:0] rel_clr;
   logic [NKEY-1:0] mask_rd;
   logic            wr_en;
   logic            unused_din;

   assign wr_en      = en & wr;
   assign press_clr  = wr_en ? din[8 +: NKEY]  : '0;
   assign rel_clr    = wr_en ? din[16 +: NKEY] : '0;
   assign unused_din = ^din;

   // First flop keeps the raw active-low level; inversion happens into syn.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= '1;
         syn_reg  <= '0;
      end else begin
         meta_reg <= key_n;
         syn_reg  <= ~meta_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NKEY; gi++) begin : g_key
         logic [CW-1:0] cnt_reg;
         logic          lvl_reg;
         logic          settle;

         assign settle   = (syn_reg[gi] != lvl_reg) && (cnt_reg == CNT_MAX);
         assign rise[gi] = settle & syn_reg[gi];
         assign fall[gi] = settle & ~syn_reg[gi];
         assign lvl[gi]  = lvl_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
               lvl_reg <= 1'b0;
            end else if (syn_reg[gi] == lvl_reg) begin
               cnt_reg <= '0;
            end else if (settle) begin
               cnt_reg <= '0;
               lvl_reg <= syn_reg[gi];
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   endgenerate

   // A same-cycle edge overrides the write-1-to-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         press_reg <= '0;
         rel_reg   <= '0;
      end else begin
         press_reg <= (press_reg & ~press_clr) | rise;
         rel_reg   <= (rel_reg & ~rel_clr) | fall;
      end
   end

`ifdef KEY_DEBOUNCE_IRQ_EN
   logic [NKEY-1:0] mask_reg;
   logic            irq_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_reg <= '0;
         irq_reg  <= 1'b0;
      end else begin
         if (wr_en) begin
            mask_reg <= din[24 +: NKEY];
         end
         irq_reg <= |(press_reg & mask_reg);
      end
   end

   assign mask_rd = mask_reg;
   assign irq     = irq_reg;
`else
   assign mask_rd = '0;
   assign irq     = 1'b0;
`endif

   assign key_lvl = lvl;

   always_comb begin
      dout              = '0;
      dout[0 +: NKEY]   = lvl;
      dout[8 +: NKEY]   = press_reg;
      dout[16 +: NKEY]  = rel_reg;
      dout[24 +: NKEY]  = mask_rd;
   end

endmodule
